// File: rtl/cic_cicc_config_loader.sv
// Streams a host-preloaded config image into the CIC+CICC filter chain over the
// isConfig / isConfigACK / isConfigDone handshake and reports session status.
module cic_cicc_config_loader #(
  parameter int CONFIG_WIDTH   = 32,
  parameter int BUF_DEPTH      = 512,
  parameter int ADDR_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    Host_Wr_En,
  input  logic [ADDR_WIDTH-1:0]   Host_Wr_Addr,
  input  logic [CONFIG_WIDTH-1:0] Host_Wr_Data,
  input  logic [ADDR_WIDTH:0]     Num_Words,
  input  logic                    Start,
  output logic                    Busy,
  output logic                    Load_Done,
  output logic                    Load_Error,
  output logic [1:0]              Err_Code,
  output logic [ADDR_WIDTH:0]     Words_Sent,
  output logic                    isConfig,
  output logic [CONFIG_WIDTH-1:0] Data_Config_Out,
  input  logic                    isConfigACK,
  input  logic                    isConfigDone
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH + 1)'(BUF_DEPTH);
  localparam logic [TW-1:0]       TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, PRESENT, WAIT_DONE, FIN, ERR} state_t;

  state_t                  state, stateNext;
  logic [CONFIG_WIDTH-1:0] mem [BUF_DEPTH];
  logic [CONFIG_WIDTH-1:0] rdData;
  logic [ADDR_WIDTH-1:0]   idx, rdAddr, lastIdx;
  logic [ADDR_WIDTH:0]     numWords;
  logic [TW-1:0]           toCnt;
  logic                    busyInt, startOk, startBad, ackTake, timedOut, earlyDone;

  assign busyInt    = (state == FETCH) || (state == PRESENT) || (state == WAIT_DONE);
  assign Busy       = busyInt;
  assign Load_Done  = (state == FIN);
  assign Load_Error = (state == ERR);
  assign lastIdx    = ADDR_WIDTH'(numWords - 1'b1);

  // Image buffer: host writes are locked out for the whole session
  always_ff @(posedge CLK) begin
    if (Host_Wr_En && !busyInt) mem[Host_Wr_Addr] <= Host_Wr_Data;
    rdData <= mem[rdAddr];
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    rdAddr    = idx;
    startOk   = 1'b0;
    startBad  = 1'b0;
    ackTake   = 1'b0;
    timedOut  = 1'b0;
    earlyDone = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (Num_Words == '0 || Num_Words > MAX_WORDS) begin
            startBad  = 1'b1;
            stateNext = ERR;
          end else begin
            startOk   = 1'b1;
            rdAddr    = '0;
            stateNext = FETCH;
          end
        end
      end
      FETCH: begin
        if (isConfigDone) begin
          earlyDone = 1'b1;
          stateNext = ERR;
        end else if (toCnt == TO_LAST) begin
          timedOut  = 1'b1;
          stateNext = ERR;
        end else begin
          stateNext = PRESENT;
        end
      end
      PRESENT: begin
        // Done outranks a coincident ACK: the word is not counted
        if (isConfigDone) begin
          earlyDone = 1'b1;
          stateNext = ERR;
        end else if (isConfigACK) begin
          ackTake = 1'b1;
          if (idx == lastIdx) begin
            stateNext = WAIT_DONE;
          end else begin
            rdAddr    = idx + ADDR_WIDTH'(1);
            stateNext = FETCH;
          end
        end else if (toCnt == TO_LAST) begin
          timedOut  = 1'b1;
          stateNext = ERR;
        end
      end
      WAIT_DONE: begin
        if (isConfigDone) begin
          stateNext = FIN;
        end else if (toCnt == TO_LAST) begin
          timedOut  = 1'b1;
          stateNext = ERR;
        end
      end
      FIN:     stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      idx             <= '0;
      numWords        <= '0;
      toCnt           <= '0;
      Words_Sent      <= '0;
      Err_Code        <= 2'd0;
      isConfig        <= 1'b0;
      Data_Config_Out <= '0;
    end else begin
      if (startOk || startBad) begin
        idx        <= '0;
        numWords   <= Num_Words;
        Words_Sent <= '0;
        Err_Code   <= startBad ? 2'd1 : 2'd0;
      end
      if (ackTake) begin
        Words_Sent <= Words_Sent + (ADDR_WIDTH + 1)'(1);
        if (stateNext == FETCH) idx <= idx + ADDR_WIDTH'(1);
      end
      if (timedOut)  Err_Code <= 2'd2;
      if (earlyDone) Err_Code <= 2'd3;
      if (busyInt && !ackTake) toCnt <= toCnt + TW'(1);
      else                     toCnt <= '0;
      // Strobe rises with the first presented word and stays up through later fetches
      isConfig <= (stateNext == PRESENT) || (stateNext == WAIT_DONE) ||
                  (isConfig && stateNext == FETCH);
      if (state == FETCH && stateNext == PRESENT) Data_Config_Out <= rdData;
    end
  end

endmodule

// File: tb/tb_cic_cicc_config_loader.sv
// Scoreboard bench for cic_cicc_config_loader: a responder drives ACK/Done, a monitor
// checks ACKed words and session-end pulses against queues filled from an image model.
module tb_cic_cicc_config_loader;

  localparam int TO = 100;
  localparam int M_DONE = 0, M_EARLY = 1, M_TIMEOUT = 2, M_RESET = 3;

  typedef struct {
    bit isDone;
    int code;
    int words;
    int cyc;
  } res_t;

  logic        CLK = 1'b0;
  logic        nRST, Host_Wr_En, Start, isConfigACK, isConfigDone;
  logic [8:0]  Host_Wr_Addr;
  logic [31:0] Host_Wr_Data;
  logic [9:0]  Num_Words;
  logic        Busy, Load_Done, Load_Error, isConfig;
  logic [1:0]  Err_Code;
  logic [9:0]  Words_Sent;
  logic [31:0] Data_Config_Out;

  bit [31:0]   img [512];
  logic [31:0] expWords [$];
  res_t        expRes [$];
  res_t        monRes;
  int          nCmp = 0, nErr = 0, cyc = 0, lastAckCyc = 0;
  bit          sessActive = 1'b0, cfgSeen = 1'b0, postPulse = 1'b0;

  cic_cicc_config_loader #(
    .CONFIG_WIDTH(32), .BUF_DEPTH(512), .ADDR_WIDTH(9), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .nRST(nRST), .Host_Wr_En(Host_Wr_En), .Host_Wr_Addr(Host_Wr_Addr),
    .Host_Wr_Data(Host_Wr_Data), .Num_Words(Num_Words), .Start(Start), .Busy(Busy),
    .Load_Done(Load_Done), .Load_Error(Load_Error), .Err_Code(Err_Code),
    .Words_Sent(Words_Sent), .isConfig(isConfig), .Data_Config_Out(Data_Config_Out),
    .isConfigACK(isConfigACK), .isConfigDone(isConfigDone)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Model rule: host writes land only when no session is running
  task automatic hostWrite(input int a, input logic [31:0] d);
    step();
    Host_Wr_En   = 1'b1;
    Host_Wr_Addr = 9'(a);
    Host_Wr_Data = d;
    if (!sessActive) img[a] = d;
  endtask

  task automatic writeRandom(input int n);
    for (int a = 0; a < n; a++) hostWrite(a, $urandom);
    step();
    Host_Wr_En = 1'b0;
  endtask

  // Monitor: every ACK without Done consumes one word; every pulse closes one session
  always @(negedge CLK) begin
    if (isConfig) cfgSeen = 1'b1;
    if (postPulse) begin
      postPulse = 1'b0;
      chk("isConfig-after-pulse", 64'(isConfig), 64'd0);
      chk("pulse-width", 64'({Load_Done, Load_Error}), 64'd0);
    end
    if (isConfigACK && isConfig && !isConfigDone) begin
      if (expWords.size() == 0) chk("extra-word-ack", 64'(isConfigACK), 64'd0);
      else chk("word", 64'(Data_Config_Out), 64'(expWords.pop_front()));
    end
    if (Load_Done || Load_Error) begin
      postPulse = 1'b1;
      if (expRes.size() == 0) begin
        chk("unexpected-pulse", 64'({Load_Done, Load_Error}), 64'd0);
      end else begin
        monRes = expRes.pop_front();
        chk("pulse-kind-done", 64'(Load_Done), 64'(monRes.isDone));
        chk("pulse-kind-error", 64'(Load_Error), 64'(!monRes.isDone));
        chk("Err_Code", 64'(Err_Code), 64'(monRes.code));
        chk("Words_Sent", 64'(Words_Sent), 64'(monRes.words));
        chk("isConfig-at-pulse", 64'(isConfig), 64'd0);
        chk("Busy-at-pulse", 64'(Busy), 64'd0);
        if (monRes.cyc >= 0) chk("pulse-cycle", 64'(cyc), 64'(monRes.cyc));
      end
    end
  end

  task automatic waitResult(input int limit);
    for (int i = 0; i < limit && expRes.size() != 0; i++) step();
    chk("result-arrived", 64'(expRes.size()), 64'd0);
    expRes.delete();
    repeat (2) step();
  endtask

  // Responder: ACK ackDly cycles after each word appears; next word shows 2 cycles after ACK
  task automatic respond(input int nAck, input int mode, input int ackDly);
    for (int i = 0; i < 10 && !isConfig; i++) step();
    chk("first-word-isConfig", 64'(isConfig), 64'd1);
    for (int w = 0; w < nAck; w++) begin
      repeat (ackDly) step();
      isConfigACK = 1'b1;
      lastAckCyc  = cyc;
      step();
      isConfigACK = 1'b0;
      if (w < nAck - 1) step();
    end
    case (mode)
      M_DONE: begin
        repeat (4) step();
        isConfigDone = 1'b1;
        step();
        isConfigDone = 1'b0;
      end
      M_EARLY: begin
        step();
        repeat (ackDly) step();
        isConfigACK  = 1'b1;
        isConfigDone = 1'b1;
        step();
        isConfigACK  = 1'b0;
        isConfigDone = 1'b0;
      end
      M_RESET: begin
        step();
        repeat (ackDly) step();
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        chk("rst-isConfig", 64'(isConfig), 64'd0);
        chk("rst-Busy", 64'(Busy), 64'd0);
        chk("rst-Words_Sent", 64'(Words_Sent), 64'd0);
        chk("rst-pulses", 64'({Load_Done, Load_Error}), 64'd0);
        chk("rst-Data", 64'(Data_Config_Out), 64'd0);
      end
      default: ;
    endcase
  endtask

  task automatic runSession(input int nWords, input int nAck, input int mode,
                            input int ackDly, input bit disturb);
    res_t r;
    for (int i = 0; i < nAck; i++) expWords.push_back(img[i]);
    r.isDone = (mode == M_DONE);
    r.code   = (mode == M_EARLY) ? 3 : 0;
    r.words  = nAck;
    r.cyc    = -1;
    if (mode == M_DONE || mode == M_EARLY) expRes.push_back(r);
    sessActive = 1'b1;
    step();
    Num_Words = 10'(nWords);
    Start     = 1'b1;
    step();
    Start = 1'b0;
    fork
      respond(nAck, mode, ackDly);
      begin
        if (disturb) begin
          repeat (5) step();
          hostWrite(0, 32'hDEAD_BEEF);
          Start     = 1'b1;
          Num_Words = 10'd5;
          step();
          Host_Wr_En = 1'b0;
          Start      = 1'b0;
        end
      end
    join
    if (mode == M_TIMEOUT) begin
      r.code = 2;
      r.cyc  = lastAckCyc + 1 + TO;
      expRes.push_back(r);
    end
    if (mode == M_RESET) repeat (3) step();
    else waitResult(400);
    chk("words-drained", 64'(expWords.size()), 64'd0);
    expWords.delete();
    sessActive = 1'b0;
  endtask

  task automatic runBad(input int n);
    res_t r;
    cfgSeen = 1'b0;
    step();
    Num_Words = 10'(n);
    Start     = 1'b1;
    r.isDone = 1'b0;
    r.code   = 1;
    r.words  = 0;
    r.cyc    = cyc + 1;
    expRes.push_back(r);
    step();
    Start = 1'b0;
    waitResult(10);
    chk("bad-len-isConfig-never", 64'(cfgSeen), 64'd0);
    chk("bad-len-Err_Code-held", 64'(Err_Code), 64'd1);
  endtask

  initial begin
    int n;
    nRST = 1'b0; Start = 1'b0; Host_Wr_En = 1'b0; Host_Wr_Addr = '0; Host_Wr_Data = '0;
    Num_Words = '0; isConfigACK = 1'b0; isConfigDone = 1'b0;
    repeat (3) step();
    chk("reset-isConfig", 64'(isConfig), 64'd0);
    chk("reset-Busy", 64'(Busy), 64'd0);
    chk("reset-Load_Done", 64'(Load_Done), 64'd0);
    chk("reset-Load_Error", 64'(Load_Error), 64'd0);
    chk("reset-Err_Code", 64'(Err_Code), 64'd0);
    chk("reset-Words_Sent", 64'(Words_Sent), 64'd0);
    chk("reset-Data", 64'(Data_Config_Out), 64'd0);
    nRST = 1'b1;

    for (int a = 0; a < 262; a++) hostWrite(a, 32'hA000_0000 + 32'(a));
    step();
    Host_Wr_En = 1'b0;
    runSession(262, 262, M_DONE, 1, 1'b0);
    chk("full-Words_Sent", 64'(Words_Sent), 64'd262);
    chk("full-Err_Code", 64'(Err_Code), 64'd0);

    runBad(0);
    runBad(513);

    writeRandom(20);
    runSession(20, 3, M_TIMEOUT, 1, 1'b0);
    chk("timeout-Words_Sent-held", 64'(Words_Sent), 64'd3);

    runSession(262, 5, M_EARLY, 1, 1'b0);

    writeRandom(20);
    runSession(20, 20, M_DONE, 2, 1'b1);
    runSession(3, 3, M_DONE, 1, 1'b0);

    runSession(30, 10, M_RESET, 1, 1'b0);
    runSession(12, 12, M_DONE, 1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(40, 2);
      writeRandom(n);
      runSession(n, n, M_DONE, $urandom_range(3, 1), 1'b0);
    end
    writeRandom(1);
    runSession(1, 1, M_DONE, 2, 1'b0);
    writeRandom(512);
    runSession(512, 512, M_DONE, 1, 1'b0);
    chk("max-Words_Sent", 64'(Words_Sent), 64'd512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
